rv64g_instr_scheduler: RTL and testbench
========================================

Name: rv64g_instr_scheduler

Overview:
- Parametrised successor to the single-stage instruction launcher. Holds up to DEPTH decoded instructions in an age-ordered slot buffer (slot 0 = oldest).
- Each cycle it issues the oldest instruction that is hazard-free against the regfile locks and all older buffered instructions. At most one issue and one accept per cycle.
- Sits between decoder and execution units. Adds WAR/WAW checks against older entries, blocking-instruction fencing, occupancy reporting and an optional stall counter.

Parameters:
- DEPTH, 4, number of buffered slots (>=2).
- NR, rv64g_pkg::NUM_REGS, number of architectural registers (int+fp).
- CW, $clog2(DEPTH+1), occupancy counter width (derived, localparam).

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous reset, active low
- clear_i  in  1  synchronous flush of all slots
- instr_in_i  in  $bits(decoded_instr_t)  incoming decoded instruction
- instr_in_valid_i  in  1  input valid
- instr_in_ready_o  out  1  input ready
- locks_i  in  NR  regfile lock mask
- instr_out_o  out  $bits(decoded_instr_t)  issued instruction
- instr_out_valid_o  out  1  issue valid
- instr_out_ready_i  in  1  execution accepts
- count_o  out  CW  occupied slots

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on arst_ni.
- Reset values: all slot valid bits 0; count_o=0; instr_in_ready_o=1; instr_out_valid_o=0; instr_out_o=slot 0 contents (don't-care).
- instr_in_ready_o = ~clear_i & (count_o < DEPTH). It does not depend on instr_out_ready_i.
- Accept: instr_in_valid_i & instr_in_ready_o at the edge.
- Write position:
  - New entry goes to slot count_o, or to count_o-1 if an issue occurs in the same cycle.
  - A new entry is never eligible in its arrival cycle, so minimum in-to-out latency is 1 cycle.
- Eligibility of valid slot i:
  - (reg_req & locks_i)==0.
  - (reg_req & OR of rd_onehot of older valid slots)==0, covering RAW and WAW.
  - (rd_onehot & OR of reg_req of older valid slots)==0, covering WAR.
  - If blocking=1: eligible only when i==0.
  - No older valid slot has blocking=1.
- rd_onehot: one-hot of rd. rd==0 (x0) gives an all-zero mask.
- Grant and output:
  - Grant goes to the lowest-index eligible slot.
  - instr_out_valid_o = any eligible & ~clear_i.
  - instr_out_o = granted slot.
  - Issue occurs when instr_out_valid_o & instr_out_ready_i.
- Compaction: on issue of slot k, slots k+1..count-1 shift down by one at the edge. Relative age order is preserved.
- count_o next value:
  - count + accept - issue.
  - Simultaneous accept and issue at full occupancy is impossible, because ready is low when full.
- clear_i:
  - All valid bits clear at the edge; count_o becomes 0.
  - Input is not accepted and output is not valid in the clear cycle.
  - clear_i has priority over everything.
- Environment contract: locks_i must include the rd of any instruction issued on the previous edge. The scheduler holds no post-issue lock state.
- Empty buffer: instr_out_valid_o=0.
- Full buffer: instr_in_ready_o=0 until an issue.
- Asynchronous reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: RV64G_SCHED_STALL_CNT_EN.
- When defined, add output stall_cnt_o [31:0], reset 0.
- stall_cnt_o increments each cycle with count_o>0 and instr_out_valid_o=0, excluding clear cycles. It saturates at 32'hFFFF_FFFF and is unaffected by clear_i.
- When undefined, the port and the counter are absent.

Decomposition:
- rv64g_pkg supplies decoded_instr_t (rd, reg_req, blocking) and NUM_REGS.
- Add to the package: SCHED_DEPTH=4 as the default for DEPTH.
- Sub-module rv64g_sched_hazard_ckr: combinational, one per slot.
  - Inputs: valid, instr, locks, older_rd_mask, older_req_mask, older_blocking, is_head.
  - Output: eligible.
- Arbitration reuses fixed_priority_arbiter and encoder.

Test Plan:
- Reset, then push 4 independent instructions (rd=1..4, disjoint reg_req) with locks_i=0 and out_ready=1. Each issues 1 cycle after arrival, in order; count_o peaks at 1.
- Push A (rd=5), then B reading x5, then C (rd=7, independent), with locks_i[5]=1 held for 3 cycles. C issues before A and B; B issues only after A has issued and locks_i[5] has cleared.
- WAR case: A reads x9 while locked on x3; B has rd=9. B stays ineligible while A is buffered. Release lock 3: A issues, then B issues the next cycle.
- Blocking case: push X, then F with blocking=1, then Y, all independent, with X held by a lock. F and Y do not issue until X issues. F issues only at slot 0, and Y issues after F.
- Hold out_ready=0 and push 5 instructions. count_o=4, instr_in_ready_o=0, and the 5th is held. Assert clear_i for 1 cycle: count_o=0 next cycle, no output valid in the clear cycle, and the 5th is accepted after.
- With RV64G_SCHED_STALL_CNT_EN: one entry blocked by a lock for 10 cycles gives stall_cnt_o=10. After the lock releases, the count holds.

Source files
------------

// File: rtl/rv64g_pkg.sv
// rtl/rv64g_pkg.sv - shared decoded-instruction types and scheduler defaults
// Contents:
//   NUM_REGS        architectural registers (32 int + 32 fp)
//   REG_IDX_W       register index width
//   SCHED_DEPTH     default scheduler slot count
//   decoded_instr_t {rd, reg_req, blocking}
//   rd_onehot()     destination mask; x0 yields an empty mask
package rv64g_pkg;

    localparam int NUM_REGS    = 64;
    localparam int REG_IDX_W   = $clog2(NUM_REGS);
    localparam int SCHED_DEPTH = 4;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [NUM_REGS-1:0]  reg_req;
        logic                 blocking;
    } decoded_instr_t;

    // x0 is hardwired zero, so writing it never creates a hazard.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd);
        rd_onehot = '0;
        if (rd != '0) begin
            rd_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/encoder.sv
// rtl/encoder.sv - one-hot to binary index encoder
// Ports:
//   onehot  in  N  one-hot input (zero maps to index 0)
//   idx     out W  binary index
module encoder #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | W'(i);
            end
        end
    end

endmodule

// File: rtl/fixed_priority_arbiter.sv
// rtl/fixed_priority_arbiter.sv - lowest-index-wins one-hot arbiter
// Ports:
//   req  in  N  request vector
//   gnt  out N  one-hot grant (all zero when no request)
module fixed_priority_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    // Two's-complement isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));

endmodule

// File: rtl/rv64g_sched_hazard_ckr.sv
// rtl/rv64g_sched_hazard_ckr.sv - per-slot issue eligibility check
// Ports:
//   valid           in   1         slot holds an instruction
//   instr           in   struct    slot contents
//   locks           in   NUM_REGS  regfile lock mask
//   older_rd_mask   in   NUM_REGS  OR of rd masks of older valid slots
//   older_req_mask  in   NUM_REGS  OR of reg_req of older valid slots
//   older_blocking  in   1         some older valid slot is blocking
//   is_head         in   1         slot is the oldest position
//   eligible        out  1         slot may issue this cycle
module rv64g_sched_hazard_ckr
    import rv64g_pkg::*;
(
    input  logic                valid,
    input  decoded_instr_t      instr,
    input  logic [NUM_REGS-1:0] locks,
    input  logic [NUM_REGS-1:0] older_rd_mask,
    input  logic [NUM_REGS-1:0] older_req_mask,
    input  logic                older_blocking,
    input  logic                is_head,
    output logic                eligible
);

    logic lock_hit;
    logic raw_waw_hit;
    logic war_hit;

    assign lock_hit    = |(instr.reg_req & locks);
    assign raw_waw_hit = |(instr.reg_req & older_rd_mask);
    assign war_hit     = |(rd_onehot(instr.rd) & older_req_mask);

    // A blocking instruction is a fence both ways: it waits to become the
    // head, and nothing younger passes it while it is buffered.
    assign eligible = valid & ~lock_hit & ~raw_waw_hit & ~war_hit
                    & (~instr.blocking | is_head) & ~older_blocking;

endmodule

// File: rtl/rv64g_instr_scheduler.sv
// rtl/rv64g_instr_scheduler.sv - age-ordered out-of-order instruction issue buffer
// Optional feature macro: RV64G_SCHED_STALL_CNT_EN (adds stall_cnt_o)
// Ports:
//   clk_i              in   1       clock
//   arst_ni            in   1       asynchronous reset, active low
//   clear_i            in   1       synchronous flush of all slots
//   instr_in_i         in   struct  incoming decoded instruction
//   instr_in_valid_i   in   1       input valid
//   instr_in_ready_o   out  1       input ready
//   locks_i            in   NR      regfile lock mask
//   instr_out_o        out  struct  issued instruction
//   instr_out_valid_o  out  1       issue valid
//   instr_out_ready_i  in   1       execution accepts
//   count_o            out  CW      occupied slots
//   stall_cnt_o        out  32      cycles with work buffered but nothing issuable
module rv64g_instr_scheduler
    import rv64g_pkg::*;
#(
    parameter  int DEPTH = SCHED_DEPTH,
    parameter  int NR    = NUM_REGS,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           arst_ni,
    input  logic           clear_i,
    input  decoded_instr_t instr_in_i,
    input  logic           instr_in_valid_i,
    output logic           instr_in_ready_o,
    input  logic [NR-1:0]  locks_i,
    output decoded_instr_t instr_out_o,
    output logic           instr_out_valid_o,
    input  logic           instr_out_ready_i,
    output logic [CW-1:0]  count_o
`ifdef RV64G_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]    stall_cnt_o
`endif
);

    localparam int IW = $clog2(DEPTH);

    decoded_instr_t      slot_q   [DEPTH];
    decoded_instr_t      slot_n   [DEPTH];
    decoded_instr_t      slot_up  [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    valid_n;
    logic [DEPTH-1:0]    valid_up;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_n;

    logic [NUM_REGS-1:0] older_rd  [DEPTH];
    logic [NUM_REGS-1:0] older_req [DEPTH];
    logic [DEPTH-1:0]    older_blk;
    logic [DEPTH-1:0]    eligible;
    logic [DEPTH-1:0]    grant;
    logic [IW-1:0]       grant_idx;
    logic [DEPTH-1:0]    shift_mask;
    logic [CW-1:0]       wr_pos;
    logic                accept;
    logic                issue;

    // Hazard summaries of everything older than each slot.
    always_comb begin
        logic [NUM_REGS-1:0] acc_rd;
        logic [NUM_REGS-1:0] acc_req;
        logic                acc_blk;
        acc_rd  = '0;
        acc_req = '0;
        acc_blk = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older_rd[i]  = acc_rd;
            older_req[i] = acc_req;
            older_blk[i] = acc_blk;
            if (valid_q[i]) begin
                acc_rd  = acc_rd | rd_onehot(slot_q[i].rd);
                acc_req = acc_req | slot_q[i].reg_req;
                acc_blk = acc_blk | slot_q[i].blocking;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rv64g_sched_hazard_ckr u_ckr (
            .valid          (valid_q[g]),
            .instr          (slot_q[g]),
            .locks          (locks_i),
            .older_rd_mask  (older_rd[g]),
            .older_req_mask (older_req[g]),
            .older_blocking (older_blk[g]),
            .is_head        (g == 0),
            .eligible       (eligible[g])
        );

        // Source for the compaction shift: the next-younger slot, or empty.
        if (g < DEPTH - 1) begin : g_up
            assign slot_up[g]  = slot_q[g+1];
            assign valid_up[g] = valid_q[g+1];
        end else begin : g_top
            assign slot_up[g]  = '0;
            assign valid_up[g] = 1'b0;
        end
    end

    fixed_priority_arbiter #(.N(DEPTH)) u_arb (
        .req (eligible),
        .gnt (grant)
    );

    encoder #(.N(DEPTH), .W(IW)) u_enc (
        .onehot (grant),
        .idx    (grant_idx)
    );

    assign instr_in_ready_o  = ~clear_i & (count_q < CW'(DEPTH));
    assign instr_out_valid_o = (|eligible) & ~clear_i;
    assign instr_out_o       = slot_q[grant_idx];
    assign count_o           = count_q;

    assign accept = instr_in_valid_i & instr_in_ready_o;
    assign issue  = instr_out_valid_o & instr_out_ready_i;

    // Slots at and above the granted one move down by one on issue.
    assign shift_mask = issue ? ~(grant - DEPTH'(1)) : '0;
    assign wr_pos     = issue ? (count_q - CW'(1)) : count_q;

    always_comb begin
        slot_n  = slot_q;
        valid_n = valid_q;
        count_n = count_q;
        if (clear_i) begin
            valid_n = '0;
            count_n = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (shift_mask[i]) begin
                    slot_n[i]  = slot_up[i];
                    valid_n[i] = valid_up[i];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && (CW'(i) == wr_pos)) begin
                    slot_n[i]  = instr_in_i;
                    valid_n[i] = 1'b1;
                end
            end
            count_n = count_q + CW'(accept) - CW'(issue);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            slot_q  <= '{default: '0};
            valid_q <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_n;
            valid_q <= valid_n;
            count_q <= count_n;
        end
    end

`ifdef RV64G_SCHED_STALL_CNT_EN
    // Counts cycles lost to hazards; survives clear so software can sample it.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_o <= '0;
        end else if (!clear_i && (count_q != '0) && !instr_out_valid_o
                     && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv64g_instr_scheduler.sv
// tb/tb_rv64g_instr_scheduler.sv - self-checking bench for rv64g_instr_scheduler
module tb_rv64g_instr_scheduler;
    import rv64g_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk;
    logic           arst_n;
    logic           clear;
    decoded_instr_t in_instr;
    logic           in_valid;
    logic           in_ready;
    logic [63:0]    locks;
    decoded_instr_t out_instr;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  count;
`ifdef RV64G_SCHED_STALL_CNT_EN
    logic [31:0]    stall_cnt;
`endif

    rv64g_instr_scheduler #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .arst_ni           (arst_n),
        .clear_i           (clear),
        .instr_in_i        (in_instr),
        .instr_in_valid_i  (in_valid),
        .instr_in_ready_o  (in_ready),
        .locks_i           (locks),
        .instr_out_o       (out_instr),
        .instr_out_valid_o (out_valid),
        .instr_out_ready_i (out_ready),
        .count_o           (count)
`ifdef RV64G_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic           iv;
        decoded_instr_t ins;
        logic [63:0]    lk;
        logic           ordy;
        logic           clr;
        logic           e_rdy;
        logic           e_ov;
        decoded_instr_t e_out;
        int             e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] oh(input int n);
        logic [63:0] one;
        one = 64'd1;
        return one << n;
    endfunction

    function automatic logic [63:0] rdm(input logic [5:0] rd);
        return (rd == 6'd0) ? 64'd0 : oh(int'(rd));
    endfunction

    function automatic decoded_instr_t mk(input int rd, input logic [63:0] req, input logic blk);
        decoded_instr_t d;
        d.rd       = 6'(rd);
        d.reg_req  = req;
        d.blocking = blk;
        return d;
    endfunction

    function automatic vec_t v(input logic iv, input decoded_instr_t ins, input logic [63:0] lk,
                               input logic ordy, input logic clr, input logic er,
                               input logic eo, input decoded_instr_t eout, input int ec);
        vec_t r;
        r.iv = iv; r.ins = ins; r.lk = lk; r.ordy = ordy; r.clr = clr;
        r.e_rdy = er; r.e_ov = eo; r.e_out = eout; r.e_cnt = ec;
        return r;
    endfunction

    task automatic drive(input logic iv, input decoded_instr_t ins, input logic [63:0] lk,
                         input logic ordy, input logic clr);
        in_valid  = iv;
        in_instr  = ins;
        locks     = lk;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic apply_reset();
        drive(1'b0, '0, 64'd0, 1'b0, 1'b0);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    decoded_instr_t nop;
    decoded_instr_t i1, i2, i3, i4, a, b, c, wa, wb, x, f, y;
    decoded_instr_t d1, d2, d3, d4, d5, z1, z2, e;

    // Reference model state for the random phase.
    decoded_instr_t mq[$];
    logic [63:0]    prev_lock;
    longint         stall_m;

    initial begin
        nop = '0;
        arst_n = 1'b0;
        drive(1'b0, '0, 64'd0, 1'b0, 1'b0);
        #2;
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
`ifdef RV64G_SCHED_STALL_CNT_EN
        chk("rst_stall", 128'(stall_cnt), 128'd0);
`endif
        @(negedge clk);
        arst_n = 1'b1;

        i1 = mk(1, oh(1), 0);  i2 = mk(2, oh(2), 0);
        i3 = mk(3, oh(3), 0);  i4 = mk(4, oh(4), 0);
        a  = mk(5, oh(5), 0);  b  = mk(6, oh(5) | oh(6), 0);  c = mk(7, oh(7), 0);
        wa = mk(10, oh(3) | oh(9) | oh(10), 0);  wb = mk(9, oh(9) | oh(11), 0);
        x  = mk(12, oh(12) | oh(13), 0);  f = mk(14, oh(14), 1);  y = mk(15, oh(15), 0);
        d1 = mk(16, oh(16), 0); d2 = mk(17, oh(17), 0); d3 = mk(18, oh(18), 0);
        d4 = mk(19, oh(19), 0); d5 = mk(20, oh(20), 0);
        z1 = mk(0, oh(22), 0);  z2 = mk(23, oh(0) | oh(23), 0);

        // Independent stream: one-cycle latency, occupancy never above 1.
        tbl.push_back(v(1, i1, 0, 1, 0, 1, 0, nop, 0));
        tbl.push_back(v(1, i2, 0, 1, 0, 1, 1, i1, 1));
        tbl.push_back(v(1, i3, 0, 1, 0, 1, 1, i2, 1));
        tbl.push_back(v(1, i4, 0, 1, 0, 1, 1, i3, 1));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 1, i4, 1));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 0, nop, 0));
        // RAW: C overtakes locked A and dependent B.
        tbl.push_back(v(1, a, 0, 1, 0, 1, 0, nop, 0));
        tbl.push_back(v(1, b, oh(5), 1, 0, 1, 0, nop, 1));
        tbl.push_back(v(1, c, oh(5), 1, 0, 1, 0, nop, 2));
        tbl.push_back(v(0, nop, oh(5), 1, 0, 1, 1, c, 3));
        tbl.push_back(v(0, nop, oh(7), 1, 0, 1, 1, a, 2));
        tbl.push_back(v(0, nop, oh(5), 1, 0, 1, 0, nop, 1));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 1, b, 1));
        tbl.push_back(v(0, nop, oh(6), 1, 0, 1, 0, nop, 0));
        // WAR: B writes x9 that older A still reads.
        tbl.push_back(v(1, wa, oh(3), 1, 0, 1, 0, nop, 0));
        tbl.push_back(v(1, wb, oh(3), 1, 0, 1, 0, nop, 1));
        tbl.push_back(v(0, nop, oh(3), 1, 0, 1, 0, nop, 2));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 1, wa, 2));
        tbl.push_back(v(0, nop, oh(10), 1, 0, 1, 1, wb, 1));
        tbl.push_back(v(0, nop, oh(9), 1, 0, 1, 0, nop, 0));
        // Blocking fence.
        tbl.push_back(v(1, x, oh(13), 1, 0, 1, 0, nop, 0));
        tbl.push_back(v(1, f, oh(13), 1, 0, 1, 0, nop, 1));
        tbl.push_back(v(1, y, oh(13), 1, 0, 1, 0, nop, 2));
        tbl.push_back(v(0, nop, oh(13), 1, 0, 1, 0, nop, 3));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 1, x, 3));
        tbl.push_back(v(0, nop, oh(12), 1, 0, 1, 1, f, 2));
        tbl.push_back(v(0, nop, oh(14), 1, 0, 1, 1, y, 1));
        tbl.push_back(v(0, nop, oh(15), 1, 0, 1, 0, nop, 0));
        // Fill to full with backpressure, then clear.
        tbl.push_back(v(1, d1, 0, 0, 0, 1, 0, nop, 0));
        tbl.push_back(v(1, d2, 0, 0, 0, 1, 1, d1, 1));
        tbl.push_back(v(1, d3, 0, 0, 0, 1, 1, d1, 2));
        tbl.push_back(v(1, d4, 0, 0, 0, 1, 1, d1, 3));
        tbl.push_back(v(1, d5, 0, 0, 0, 0, 1, d1, 4));
        tbl.push_back(v(1, d5, 0, 0, 1, 0, 0, nop, 4));
        tbl.push_back(v(1, d5, 0, 0, 0, 1, 0, nop, 0));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 1, d5, 1));
        tbl.push_back(v(0, nop, oh(20), 1, 0, 1, 0, nop, 0));
        // x0 destination creates no hazard for a reader of bit 0.
        tbl.push_back(v(1, z1, oh(22), 1, 0, 1, 0, nop, 0));
        tbl.push_back(v(1, z2, oh(22), 1, 0, 1, 0, nop, 1));
        tbl.push_back(v(0, nop, oh(22), 1, 0, 1, 1, z2, 2));
        tbl.push_back(v(0, nop, oh(23), 1, 0, 1, 1, z1, 1));
        tbl.push_back(v(0, nop, 0, 1, 0, 1, 0, nop, 0));

        foreach (tbl[n]) begin
            drive(tbl[n].iv, tbl[n].ins, tbl[n].lk, tbl[n].ordy, tbl[n].clr);
            #1;
            chk($sformatf("tbl%0d_in_ready", n), 128'(in_ready), 128'(tbl[n].e_rdy));
            chk($sformatf("tbl%0d_out_valid", n), 128'(out_valid), 128'(tbl[n].e_ov));
            chk($sformatf("tbl%0d_count", n), 128'(count), 128'(tbl[n].e_cnt));
            if (tbl[n].e_ov) begin
                chk($sformatf("tbl%0d_out_instr", n), 128'(out_instr), 128'(tbl[n].e_out));
            end
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle with entries buffered.
        drive(1'b1, i1, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, i2, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, nop, 64'd0, 1'b0, 1'b0);
        #1;
        chk("pre_arst_count", 128'(count), 128'd2);
        #1;
        arst_n = 1'b0;
        #1;
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        arst_n = 1'b1;

`ifdef RV64G_SCHED_STALL_CNT_EN
        e = mk(21, oh(21), 0);
        drive(1'b1, e, oh(21), 1'b1, 1'b0);
        @(negedge clk);
        repeat (10) begin
            drive(1'b0, nop, oh(21), 1'b1, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, nop, 64'd0, 1'b1, 1'b0);
        #1;
        chk("stall_after_10", 128'(stall_cnt), 128'd10);
        chk("stall_release_valid", 128'(out_valid), 128'd1);
        @(negedge clk);
        drive(1'b0, nop, oh(21), 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_hold", 128'(stall_cnt), 128'd10);
        @(negedge clk);
`else
        e = nop;
`endif

        // Randomized run against the queue model.
        apply_reset();
        mq.delete();
        prev_lock = 64'd0;
        stall_m   = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic           iv, ordy, clr, e_rdy, e_ov, acc, iss;
            decoded_instr_t ins;
            logic [63:0]    lk;
            int             k;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 59) == 0);
            ins  = mk($urandom_range(0, 7),
                      64'($urandom_range(0, 255)) & 64'($urandom_range(0, 255)),
                      ($urandom_range(0, 7) == 0));
            lk = prev_lock;
            if ($urandom_range(0, 1) == 1) lk = lk | oh($urandom_range(0, 7));
            drive(iv, ins, lk, ordy, clr);
            #1;
            // Oldest instruction with no conflict against locks or any older entry.
            k = -1;
            for (int i = 0; i < mq.size(); i++) begin
                logic ok;
                ok = ((mq[i].reg_req & lk) == 64'd0) && !(mq[i].blocking && i != 0);
                for (int j = 0; j < i; j++) begin
                    if ((mq[i].reg_req & rdm(mq[j].rd)) != 64'd0) ok = 1'b0;
                    if ((rdm(mq[i].rd) & mq[j].reg_req) != 64'd0) ok = 1'b0;
                    if (mq[j].blocking) ok = 1'b0;
                end
                if (ok && k < 0) k = i;
            end
            e_rdy = !clr && (mq.size() < DEPTH);
            e_ov  = !clr && (k >= 0);
            chk($sformatf("rnd%0d_in_ready", cyc), 128'(in_ready), 128'(e_rdy));
            chk($sformatf("rnd%0d_out_valid", cyc), 128'(out_valid), 128'(e_ov));
            chk($sformatf("rnd%0d_count", cyc), 128'(count), 128'(mq.size()));
            if (e_ov) chk($sformatf("rnd%0d_out_instr", cyc), 128'(out_instr), 128'(mq[k]));
`ifdef RV64G_SCHED_STALL_CNT_EN
            chk($sformatf("rnd%0d_stall", cyc), 128'(stall_cnt), 128'(stall_m));
`endif
            acc = iv && e_rdy;
            iss = e_ov && ordy;
            if (!clr && mq.size() > 0 && !e_ov) stall_m++;
            prev_lock = iss ? rdm(mq[k].rd) : 64'd0;
            if (clr) begin
                mq.delete();
            end else begin
                if (iss) mq.delete(k);
                if (acc) mq.push_back(ins);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
